// File: rtl/rad4_fft4_stream.sv
// rad4_fft4_stream: streaming complex 4-point radix-4 DFT.
// It loads four samples, computes all bins in one registered stage, then streams the bins in order.
module rad4_fft4_stream #(
    parameter int DW    = 8,
    parameter bit SCALE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    input  logic                 in_inv,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW+1:0] out_re,
    output logic signed [DW+1:0] out_im,
    output logic [1:0]           out_idx,
    output logic                 out_last,
    output logic                 busy
);
    localparam int OW = DW + 2;

    typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;

    state_t               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d, idx_q, idx_d;
    logic                 inv_q, inv_d;
    logic signed [DW-1:0] xr_q [4], xr_d [4], xi_q [4], xi_d [4];
    logic signed [OW-1:0] br_q [4], br_d [4], bi_q [4], bi_d [4];
    logic signed [OW-1:0] er [4], ei [4], fr [4], fi [4];
    logic signed [OW-1:0] s0r, s0i, s1r, s1i, d0r, d0i, d1r, d1i;

    // Widen first: DW+2 bits hold any sum of four DW-bit samples.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            er[i] = {{2{xr_q[i][DW-1]}}, xr_q[i]};
            ei[i] = {{2{xi_q[i][DW-1]}}, xi_q[i]};
        end
        s0r = er[0] + er[2];
        s0i = ei[0] + ei[2];
        s1r = er[1] + er[3];
        s1i = ei[1] + ei[3];
        d0r = er[0] - er[2];
        d0i = ei[0] - ei[2];
        d1r = er[1] - er[3];
        d1i = ei[1] - ei[3];
        fr[0] = s0r + s1r;
        fi[0] = s0i + s1i;
        fr[2] = s0r - s1r;
        fi[2] = s0i - s1i;
        // Inverse conjugates the twiddle, which swaps bins 1 and 3.
        fr[1] = inv_q ? d0r - d1i : d0r + d1i;
        fi[1] = inv_q ? d0i + d1r : d0i - d1r;
        fr[3] = inv_q ? d0r + d1i : d0r - d1i;
        fi[3] = inv_q ? d0i - d1r : d0i + d1r;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        inv_d   = inv_q;
        xr_d    = xr_q;
        xi_d    = xi_q;
        br_d    = br_q;
        bi_d    = bi_q;
        case (state_q)
            LOAD: if (in_valid) begin
                xr_d[cnt_q] = in_re;
                xi_d[cnt_q] = in_im;
                inv_d       = (cnt_q == 2'd0) ? in_inv : inv_q;
                cnt_d       = cnt_q + 2'd1;
                state_d     = (cnt_q == 2'd3) ? CALC : LOAD;
            end
            CALC: begin
                for (int k = 0; k < 4; k++) begin
                    br_d[k] = SCALE ? fr[k] >>> 2 : fr[k];
                    bi_d[k] = SCALE ? fi[k] >>> 2 : fi[k];
                end
                idx_d   = 2'd0;
                state_d = OUT;
            end
            OUT: if (out_ready) begin
                idx_d   = idx_q + 2'd1;
                cnt_d   = 2'd0;
                state_d = (idx_q == 2'd3) ? LOAD : OUT;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= 2'd0;
            idx_q   <= 2'd0;
            inv_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                xr_q[i] <= '0;
                xi_q[i] <= '0;
                br_q[i] <= '0;
                bi_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            inv_q   <= inv_d;
            xr_q    <= xr_d;
            xi_q    <= xi_d;
            br_q    <= br_d;
            bi_q    <= bi_d;
        end
    end

    assign in_ready  = state_q == LOAD;
    assign out_valid = state_q == OUT;
    assign out_re    = out_valid ? br_q[idx_q] : '0;
    assign out_im    = out_valid ? bi_q[idx_q] : '0;
    assign out_idx   = idx_q;
    assign out_last  = out_valid && idx_q == 2'd3;
    assign busy      = !(state_q == LOAD && cnt_q == 2'd0);
endmodule
